// File: rtl/wb_retire_stage_pkg.sv
//------------------------------------------------------------------------------
// wb_retire_stage_pkg
//   Shared sizing helpers for the writeback retire buffer: entry width and the
//   bit offset of each field inside a packed retire entry.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_retire_stage_pkg;

  localparam int WB_FWD_PORTS = 2;

  // Entry layout, MSB to LSB: {pc, rf_we, waddr, wdata, hilo_we, hi, lo}
  function automatic int wb_entry_wd(input int pc_w, input int addr_w, input int data_w);
    return pc_w + 1 + addr_w + data_w + 1 + 2 * data_w;
  endfunction

  function automatic int wb_off_hi(input int data_w);
    return data_w;
  endfunction

  function automatic int wb_off_hilo_we(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int wb_off_wdata(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int wb_off_waddr(input int data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int wb_off_rf_we(input int data_w, input int addr_w);
    return 3 * data_w + 1 + addr_w;
  endfunction

  function automatic int wb_off_pc(input int data_w, input int addr_w);
    return 3 * data_w + 2 + addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_retire_fifo.sv
//------------------------------------------------------------------------------
// wb_retire_fifo
//   In-order retire storage with occupancy-derived full/empty; exposes every
//   slot and its valid bit so the forwarding CAM can search in age order.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_retire_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [DEPTH*WIDTH-1:0]   entries,
  output logic [DEPTH-1:0]         valid,
  output logic [PTR_W-1:0]         rd_ptr,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) r_mem[r_wr_ptr] <= wdata;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_rel;
    assign w_rel                       = PTR_W'(i) - r_rd_ptr;
    assign valid[i]                    = CNT_W'(w_rel) < r_count;
    assign entries[i*WIDTH +: WIDTH]   = r_mem[i];
  end

  assign head   = r_mem[r_rd_ptr];
  assign rd_ptr = r_rd_ptr;
  assign count  = r_count;
  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/wb_retire_stage.sv
//------------------------------------------------------------------------------
// wb_retire_stage
//   Writeback retire buffer: MEM handshake into a FIFO, one registered commit
//   per cycle to regfile/HI-LO, ID forwarding and debug trace.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 4,
  parameter int FWD_PORTS = WB_FWD_PORTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PC_W-1:0]               in_pc,
  input  logic                          in_rf_we,
  input  logic [ADDR_W-1:0]             in_rf_waddr,
  input  logic [DATA_W-1:0]             in_rf_wdata,
  input  logic                          in_hilo_we,
  input  logic [DATA_W-1:0]             in_hi,
  input  logic [DATA_W-1:0]             in_lo,
  input  logic                          rf_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          hilo_we,
  output logic [DATA_W-1:0]             hi_wdata,
  output logic [DATA_W-1:0]             lo_wdata,
  input  logic [FWD_PORTS*ADDR_W-1:0]   fwd_raddr,
  output logic [FWD_PORTS-1:0]          fwd_hit,
  output logic [FWD_PORTS*DATA_W-1:0]   fwd_data,
  output logic                          fwd_hilo_hit,
  output logic [DATA_W-1:0]             fwd_hi,
  output logic [DATA_W-1:0]             fwd_lo,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [PC_W-1:0]               debug_wb_pc,
  output logic [3:0]                    debug_wb_rf_wen,
  output logic [ADDR_W-1:0]             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]             debug_wb_rf_wdata
);

  localparam int ENTRY_W   = wb_entry_wd(PC_W, ADDR_W, DATA_W);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int O_HI      = wb_off_hi(DATA_W);
  localparam int O_HILO_WE = wb_off_hilo_we(DATA_W);
  localparam int O_WDATA   = wb_off_wdata(DATA_W);
  localparam int O_WADDR   = wb_off_waddr(DATA_W);
  localparam int O_RF_WE   = wb_off_rf_we(DATA_W, ADDR_W);
  localparam int O_PC      = wb_off_pc(DATA_W, ADDR_W);

  logic                       w_retire;
  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  logic [ENTRY_W-1:0]         w_in_entry;
  logic [ENTRY_W-1:0]         w_head;
  logic [DEPTH*ENTRY_W-1:0]   w_entries;
  logic [DEPTH-1:0]           w_valid;
  logic [PTR_W-1:0]           w_rd_ptr;
  logic [ENTRY_W-1:0]         w_ent [DEPTH];

  logic [PC_W-1:0]            r_pc;
  logic                       r_rf_we;
  logic [ADDR_W-1:0]          r_rf_waddr;
  logic [DATA_W-1:0]          r_rf_wdata;
  logic                       r_hilo_we;
  logic [DATA_W-1:0]          r_hi;
  logic [DATA_W-1:0]          r_lo;

  assign w_in_entry = {in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_hilo_we, in_hi, in_lo};

  // A pop frees a slot in the same cycle, so a full buffer still accepts while draining.
  assign w_retire = !w_empty && rf_ready && !flush;
  assign in_ready = !w_full || w_retire;
  assign w_push   = in_valid && in_ready && !flush;

  wb_retire_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (w_push),
    .pop     (w_retire),
    .wdata   (w_in_entry),
    .head    (w_head),
    .entries (w_entries),
    .valid   (w_valid),
    .rd_ptr  (w_rd_ptr),
    .count   (occupancy),
    .full    (w_full),
    .empty   (w_empty)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign w_ent[i] = w_entries[i*ENTRY_W +: ENTRY_W];
  end

  // Commit register clears on idle cycles so the write enables are single pulses.
  always_ff @(posedge clk) begin
    if (rst || !w_retire) begin
      r_pc       <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_hilo_we  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_pc       <= w_head[O_PC +: PC_W];
      r_rf_we    <= w_head[O_RF_WE];
      r_rf_waddr <= w_head[O_WADDR +: ADDR_W];
      r_rf_wdata <= w_head[O_WDATA +: DATA_W];
      r_hilo_we  <= w_head[O_HILO_WE];
      r_hi       <= w_head[O_HI +: DATA_W];
      r_lo       <= w_head[DATA_W-1:0];
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides; commit reg is oldest of all.
  for (genvar k = 0; k < FWD_PORTS; k++) begin : g_fwd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;
    logic [PTR_W-1:0]  w_idx;

    assign w_raddr = fwd_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      w_idx  = '0;
      if (w_raddr != '0) begin
        if (r_rf_we && (r_rf_waddr == w_raddr)) begin
          w_hit  = 1'b1;
          w_data = r_rf_wdata;
        end
        for (int j = 0; j < DEPTH; j++) begin
          w_idx = w_rd_ptr + PTR_W'(j);
          if (w_valid[w_idx] && w_ent[w_idx][O_RF_WE] &&
              (w_ent[w_idx][O_WADDR +: ADDR_W] == w_raddr)) begin
            w_hit  = 1'b1;
            w_data = w_ent[w_idx][O_WDATA +: DATA_W];
          end
        end
      end
    end

    assign fwd_hit[k]                    = w_hit;
    assign fwd_data[k*DATA_W +: DATA_W]  = w_data;
  end

  logic [PTR_W-1:0] w_hl_idx;

  always_comb begin
    fwd_hilo_hit = r_hilo_we;
    fwd_hi       = r_hilo_we ? r_hi : '0;
    fwd_lo       = r_hilo_we ? r_lo : '0;
    w_hl_idx     = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_hl_idx = w_rd_ptr + PTR_W'(j);
      if (w_valid[w_hl_idx] && w_ent[w_hl_idx][O_HILO_WE]) begin
        fwd_hilo_hit = 1'b1;
        fwd_hi       = w_ent[w_hl_idx][O_HI +: DATA_W];
        fwd_lo       = w_ent[w_hl_idx][DATA_W-1:0];
      end
    end
  end

  assign rf_we             = r_rf_we;
  assign rf_waddr          = r_rf_waddr;
  assign rf_wdata          = r_rf_wdata;
  assign hilo_we           = r_hilo_we;
  assign hi_wdata          = r_hi;
  assign lo_wdata          = r_lo;

  assign debug_wb_pc       = (r_rf_we || r_hilo_we) ? r_pc : '0;
  assign debug_wb_rf_wen   = {4{r_rf_we}};
  assign debug_wb_rf_wnum  = r_rf_waddr;
  assign debug_wb_rf_wdata = r_rf_wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
//------------------------------------------------------------------------------
// tb_wb_retire_stage
//   Directed and random stimulus against a queue-based retire/forwarding model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_retire_stage;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_rf_we, in_hilo_we, rf_ready;
  logic [31:0] in_pc, in_rf_wdata, in_hi, in_lo;
  logic [4:0]  in_rf_waddr;
  logic        rf_we, hilo_we, fwd_hilo_hit;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, hi_wdata, lo_wdata, fwd_hi, fwd_lo, debug_wb_pc, debug_wb_rf_wdata;
  logic [9:0]  fwd_raddr;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic [2:0]  occupancy;
  logic [3:0]  debug_wb_rf_wen;

  ent_t mq[$];
  ent_t mc;
  int   errors = 0;
  int   checks = 0;
  int   pulses;

  always #5 clk = ~clk;

  wb_retire_stage #(
    .DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(DEPTH), .FWD_PORTS(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
    .in_hilo_we(in_hilo_we), .in_hi(in_hi), .in_lo(in_lo),
    .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_hilo_hit(fwd_hilo_hit), .fwd_hi(fwd_hi), .fwd_lo(fwd_lo),
    .occupancy(occupancy),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic hwe,
                              input logic [31:0] hi, input logic [31:0] lo);
    ent_t e;
    e.pc = pc; e.rf_we = we; e.waddr = a; e.wdata = d;
    e.hilo_we = hwe; e.hi = hi; e.lo = lo;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom, ($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom,
              ($urandom % 4) == 0, $urandom, $urandom);
  endfunction

  task automatic drive(input ent_t e, input logic v);
    in_valid = v; in_pc = e.pc; in_rf_we = e.rf_we; in_rf_waddr = e.waddr;
    in_rf_wdata = e.wdata; in_hilo_we = e.hilo_we; in_hi = e.hi; in_lo = e.lo;
  endtask

  // Reference: the FIFO is a queue (front = oldest), the commit register a single entry.
  task automatic model_step();
    int   sz;
    bit   ret, psh;
    ent_t nc;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      mc = '0;
      return;
    end
    ret = !flush && sz > 0 && rf_ready;
    psh = !flush && in_valid && (sz < DEPTH || ret);
    nc  = '0;
    if (ret) nc = mq[0];
    if (flush) mq.delete();
    else begin
      if (ret) void'(mq.pop_front());
      if (psh) mq.push_back(mk(in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_hilo_we, in_hi, in_lo));
    end
    mc = nc;
  endtask

  task automatic exp_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    if (a == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].rf_we && mq[i].waddr == a) begin
        hit = 1'b1; d = mq[i].wdata; return;
      end
    end
    if (mc.rf_we && mc.waddr == a) begin
      hit = 1'b1; d = mc.wdata;
    end
  endtask

  task automatic exp_hilo(output logic hit, output logic [31:0] hi, output logic [31:0] lo);
    hit = 1'b0; hi = '0; lo = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].hilo_we) begin
        hit = 1'b1; hi = mq[i].hi; lo = mq[i].lo; return;
      end
    end
    if (mc.hilo_we) begin
      hit = 1'b1; hi = mc.hi; lo = mc.lo;
    end
  endtask

  task automatic check_all();
    int          sz;
    logic        hit;
    logic [31:0] d, hi, lo;
    sz = mq.size();
    check("in_ready", in_ready, (sz < DEPTH) || (sz > 0 && rf_ready && !flush));
    check("occupancy", occupancy, sz);
    check("rf_we", rf_we, mc.rf_we);
    check("rf_waddr", rf_waddr, mc.waddr);
    check("rf_wdata", rf_wdata, mc.wdata);
    check("hilo_we", hilo_we, mc.hilo_we);
    check("hi_wdata", hi_wdata, mc.hi);
    check("lo_wdata", lo_wdata, mc.lo);
    check("dbg_pc", debug_wb_pc, (mc.rf_we || mc.hilo_we) ? mc.pc : 32'd0);
    check("dbg_wen", debug_wb_rf_wen, mc.rf_we ? 4'hF : 4'h0);
    check("dbg_wnum", debug_wb_rf_wnum, mc.waddr);
    check("dbg_wdata", debug_wb_rf_wdata, mc.wdata);
    for (int k = 0; k < 2; k++) begin
      exp_fwd(fwd_raddr[k*5 +: 5], hit, d);
      check($sformatf("fwd_hit%0d", k), fwd_hit[k], hit);
      check($sformatf("fwd_data%0d", k), fwd_data[k*32 +: 32], d);
    end
    exp_hilo(hit, hi, lo);
    check("fwd_hilo_hit", fwd_hilo_hit, hit);
    check("fwd_hi", fwd_hi, hi);
    check("fwd_lo", fwd_lo, lo);
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks land 3 units after it.
  task automatic cycle();
    #2;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rf_ready = 1'b0; fwd_raddr = '0;
    mc = '0;
    drive('0, 1'b0);

    // 1: reset
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    check("rst_occ", occupancy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_dbg_pc", debug_wb_pc, 0);
    check("rst_dbg_wen", debug_wb_rf_wen, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    cycle();

    // 2: single write, visible two edges after the push
    rf_ready = 1'b1;
    drive(mk(32'hBFC0_0000, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 0, 0), 1'b1);
    cycle();
    drive('0, 1'b0);
    cycle();
    check("t2_rf_we", rf_we, 1);
    check("t2_waddr", rf_waddr, 3);
    check("t2_wdata", rf_wdata, 32'h1234_5678);
    check("t2_dbg_wen", debug_wb_rf_wen, 4'hF);
    check("t2_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
    cycle();

    // 3: backpressure to full, then push accepted while draining at full
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(rnd_ent(), 1'b1);
      cycle();
    end
    check("t3_occ_full", occupancy, 4);
    check("t3_ready_full", in_ready, 0);
    rf_ready = 1'b1;
    drive(rnd_ent(), 1'b1);
    #1;
    check("t3_ready_drain", in_ready, 1);
    cycle();
    drive('0, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // 4: forwarding priority, youngest FIFO entry over older entry and commit reg
    fwd_raddr = {5'd0, 5'd5};
    rf_ready  = 1'b0;
    drive(mk(32'h100, 1'b1, 5'd5, 32'h0, 1'b0, 0, 0), 1'b1);
    cycle();
    drive(mk(32'h104, 1'b1, 5'd5, 32'h1, 1'b0, 0, 0), 1'b1);
    cycle();
    rf_ready = 1'b1;
    drive(mk(32'h108, 1'b1, 5'd5, 32'h2, 1'b0, 0, 0), 1'b1);
    cycle();
    check("t4_commit_r5", rf_waddr, 5);
    check("t4_hit0", fwd_hit[0], 1);
    check("t4_data0", fwd_data[31:0], 32'h2);
    rf_ready = 1'b0;
    drive(mk(32'h10C, 1'b1, 5'd0, 32'h99, 1'b0, 0, 0), 1'b1);
    cycle();
    check("t4_hit1_r0", fwd_hit[1], 0);
    check("t4_data1_r0", fwd_data[63:32], 0);
    check("t4_data0_again", fwd_data[31:0], 32'h2);
    rf_ready = 1'b1;
    drive('0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();

    // 5: flush with a commit in progress and an incoming entry
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(32'h200 + 32'(i * 4), 1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b0, 0, 0), 1'b1);
      cycle();
    end
    rf_ready = 1'b1;
    drive('0, 1'b0);
    cycle();
    check("t5_occ_pre", occupancy, 3);
    check("t5_commit_we", rf_we, 1);
    check("t5_commit_addr", rf_waddr, 10);
    flush = 1'b1;
    drive(mk(32'h300, 1'b1, 5'd20, 32'hEE, 1'b0, 0, 0), 1'b1);
    cycle();
    check("t5_occ_post", occupancy, 0);
    check("t5_no_we", rf_we, 0);
    flush = 1'b0;
    drive('0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_no_we_after", rf_we, 0);
    end

    // 6: HI/LO forwarding and single hilo_we pulse
    rf_ready = 1'b0;
    drive(mk(32'h400, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA, 32'hB), 1'b1);
    cycle();
    drive(mk(32'h404, 1'b0, 5'd0, 32'h0, 1'b0, 0, 0), 1'b1);
    cycle();
    drive('0, 1'b0);
    cycle();
    check("t6_hilo_hit", fwd_hilo_hit, 1);
    check("t6_fwd_hi", fwd_hi, 32'hA);
    check("t6_fwd_lo", fwd_lo, 32'hB);
    rf_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (hilo_we) begin
        pulses++;
        check("t6_hi_wdata", hi_wdata, 32'hA);
        check("t6_lo_wdata", lo_wdata, 32'hB);
      end
    end
    check("t6_pulses", pulses, 1);
    check("t6_hilo_hit_end", fwd_hilo_hit, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rf_ready  = ($urandom % 4) != 0;
      flush     = ($urandom % 25) == 0;
      fwd_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      drive(rnd_ent(), ($urandom % 3) != 0);
      cycle();
    end
    flush = 1'b0;
    drive('0, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
